// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage issuing word loads/stores over a req/ack handshake,
// stalling upstream while an access is outstanding and parking in a sticky error state.
module mem_stage #(
    parameter int WORD     = 32,
    parameter int REG_SIZE = 5,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD-1:0]     writeDataM,
    input  logic [WORD-1:0]     ALUResultM,
    input  logic [WORD-1:0]     pcM,
    input  logic [REG_SIZE-1:0] writeRegM,
    input  logic                regWriteM,
    input  logic                memWriteM,
    input  logic                mem2regM,
    input  logic                zeroM,
    input  logic                branchM,
    input  logic                finishM,
    input  logic                validM,
    output logic                stallM,
    output logic                pcSrcM,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [WORD-1:0]     dmem_addr,
    output logic [WORD-1:0]     dmem_wdata,
    input  logic                dmem_ack,
    input  logic [WORD-1:0]     dmem_rdata,
    output logic [WORD-1:0]     readDataW,
    output logic [WORD-1:0]     ALUResultW,
    output logic [WORD-1:0]     pcW,
    output logic [REG_SIZE-1:0] writeRegW,
    output logic                regWriteW,
    output logic                mem2regW,
    output logic                finishW,
    output logic                validW,
    output logic                errW
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [WORD-1:0]     rdata_q, rdata_d, alu_q, alu_d, pc_q, pc_d;
    logic [REG_SIZE-1:0] wreg_q, wreg_d;
    logic                rw_q, rw_d, m2r_q, m2r_d, fin_q, fin_d, val_q, val_d;
    logic                mem_op, misal, req, stall;

    always_comb begin
        mem_op  = validM & (memWriteM | mem2regM);
        misal   = ALUResultM[1:0] != 2'b00;
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && misal) begin
                    stall   = 1'b1;
                    state_d = ERROR;
                end else if (mem_op) begin
                    req = 1'b1;
                    if (!dmem_ack) begin
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dmem_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall   = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_d == CW'(TIMEOUT)) ? ERROR : WAIT;
                end
            end
            default: stall = 1'b1;
        endcase
        err_d   = err_q | (state_d == ERROR);
        // stall cycles load a fully zeroed bubble so W stays deterministic
        rdata_d = (!stall && validM && mem2regM && !memWriteM) ? dmem_rdata : '0;
        alu_d   = stall ? '0 : ALUResultM;
        pc_d    = stall ? '0 : pcM;
        wreg_d  = stall ? '0 : writeRegM;
        rw_d    = !stall & regWriteM;
        m2r_d   = !stall & mem2regM;
        fin_d   = !stall & finishM;
        val_d   = !stall & validM;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            alu_q   <= '0;
            pc_q    <= '0;
            wreg_q  <= '0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            fin_q   <= 1'b0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            pc_q    <= pc_d;
            wreg_q  <= wreg_d;
            rw_q    <= rw_d;
            m2r_q   <= m2r_d;
            fin_q   <= fin_d;
            val_q   <= val_d;
        end
    end

    // reset masks the combinational handshake so a held mem op cannot request during reset
    assign dmem_req   = req & !reset;
    assign dmem_we    = memWriteM & dmem_req;
    assign stallM     = stall & !reset;
    assign pcSrcM     = validM & branchM & zeroM & !stallM & !reset;
    assign dmem_addr  = ALUResultM;
    assign dmem_wdata = writeDataM;
    assign readDataW  = rdata_q;
    assign ALUResultW = alu_q;
    assign pcW        = pc_q;
    assign writeRegW  = wreg_q;
    assign regWriteW  = rw_q;
    assign mem2regW   = m2r_q;
    assign finishW    = fin_q;
    assign validW     = val_q;
    assign errW       = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus hand-written multi-cycle sequences for mem_stage.
module tb_mem_stage;
    logic        clk = 0, reset = 1;
    logic [31:0] writeDataM = 0, ALUResultM = 0, pcM = 0, dmem_rdata = 0;
    logic [4:0]  writeRegM = 0;
    logic        regWriteM = 0, memWriteM = 0, mem2regM = 0, zeroM = 0, branchM = 0;
    logic        finishM = 0, validM = 0, dmem_ack = 0;
    logic        stallM, pcSrcM, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, readDataW, ALUResultW, pcW;
    logic [4:0]  writeRegW;
    logic        regWriteW, mem2regW, finishW, validW, errW;
    int          checks = 0, errors = 0;

    mem_stage #(.WORD(32), .REG_SIZE(5), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .writeDataM(writeDataM), .ALUResultM(ALUResultM), .pcM(pcM),
        .writeRegM(writeRegM), .regWriteM(regWriteM), .memWriteM(memWriteM), .mem2regM(mem2regM),
        .zeroM(zeroM), .branchM(branchM), .finishM(finishM), .validM(validM), .stallM(stallM),
        .pcSrcM(pcSrcM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .readDataW(readDataW), .ALUResultW(ALUResultW), .pcW(pcW), .writeRegW(writeRegW),
        .regWriteW(regWriteW), .mem2regW(mem2regW), .finishW(finishW), .validW(validW), .errW(errW)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v, mw, mr, br, z, rw, ack;
        logic [31:0] addr, rdata;
        logic        e_stall, e_req, e_we, e_pcsrc;
        logic [31:0] e_rd;
        logic        e_vw, e_rww;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        validM = 0; memWriteM = 0; mem2regM = 0; branchM = 0; zeroM = 0; regWriteM = 0;
        dmem_ack = 0; dmem_rdata = 0; ALUResultM = 0; writeDataM = 0;
    endtask

    task automatic load(input logic [31:0] a);
        validM = 1; mem2regM = 1; memWriteM = 0; regWriteM = 1; ALUResultM = a; dmem_ack = 0;
    endtask

    task automatic do_reset();
        #2 reset = 1;
        #1 idle_in();
        step();
        #2 reset = 0;
        step();
    endtask

    initial begin
        vecs[0] = '{1,0,1,0,0,1,1, 32'h100, 32'hDEADBEEF, 0,1,0,0, 32'hDEADBEEF, 1,1};
        vecs[1] = '{1,0,0,0,0,1,0, 32'h55,  32'h0,        0,0,0,0, 32'h0,        1,1};
        vecs[2] = '{1,0,0,1,1,0,0, 32'h8,   32'h0,        0,0,0,1, 32'h0,        1,0};
        vecs[3] = '{1,0,0,1,0,0,0, 32'h8,   32'h0,        0,0,0,0, 32'h0,        1,0};
        vecs[4] = '{0,1,1,0,0,1,0, 32'h104, 32'h77,       0,0,0,0, 32'h0,        0,1};
        vecs[5] = '{1,1,0,0,0,0,1, 32'h300, 32'h99,       0,1,1,0, 32'h0,        1,0};
        vecs[6] = '{1,0,0,0,0,1,1, 32'h60,  32'hCAFE,     0,0,0,0, 32'h0,        1,1};

        #3;
        chk("reset_validW", validW, 0);
        chk("reset_errW", errW, 0);
        chk("reset_req", dmem_req, 0);
        chk("reset_stall", stallM, 0);
        step();
        reset = 0;
        step();

        for (int i = 0; i < 7; i++) begin
            validM = vecs[i].v; memWriteM = vecs[i].mw; mem2regM = vecs[i].mr;
            branchM = vecs[i].br; zeroM = vecs[i].z; regWriteM = vecs[i].rw;
            dmem_ack = vecs[i].ack; ALUResultM = vecs[i].addr; dmem_rdata = vecs[i].rdata;
            pcM = 32'h1000 + i * 4; writeRegM = 5'(i + 1);
            #1;
            chk($sformatf("v%0d_stall", i), stallM, vecs[i].e_stall);
            chk($sformatf("v%0d_req", i), dmem_req, vecs[i].e_req);
            chk($sformatf("v%0d_we", i), dmem_we, vecs[i].e_we);
            chk($sformatf("v%0d_pcsrc", i), pcSrcM, vecs[i].e_pcsrc);
            step();
            chk($sformatf("v%0d_rdW", i), readDataW, vecs[i].e_rd);
            chk($sformatf("v%0d_validW", i), validW, vecs[i].e_vw);
            chk($sformatf("v%0d_regWriteW", i), regWriteW, vecs[i].e_rww);
            chk($sformatf("v%0d_aluW", i), ALUResultW, vecs[i].addr);
            chk($sformatf("v%0d_pcW", i), pcW, 32'h1000 + i * 4);
            chk($sformatf("v%0d_wregW", i), writeRegW, 32'(i + 1));
        end
        idle_in();
        step();

        // three-cycle store: two stall bubbles then completion
        validM = 1; memWriteM = 1; ALUResultM = 32'h200; writeDataM = 32'h12345678;
        #1;
        chk("st_c1_stall", stallM, 1);
        chk("st_c1_req", dmem_req, 1);
        chk("st_c1_we", dmem_we, 1);
        step();
        chk("st_c2_validW", validW, 0);
        chk("st_c2_stall", stallM, 1);
        chk("st_c2_req", dmem_req, 1);
        chk("st_c2_addr", dmem_addr, 32'h200);
        chk("st_c2_wdata", dmem_wdata, 32'h12345678);
        step();
        chk("st_c3_validW", validW, 0);
        dmem_ack = 1;
        #1;
        chk("st_c3_stall", stallM, 0);
        chk("st_c3_req", dmem_req, 1);
        step();
        idle_in();
        #1;
        chk("st_done_validW", validW, 1);
        chk("st_done_rdW", readDataW, 0);
        chk("st_done_aluW", ALUResultW, 32'h200);
        chk("st_done_req", dmem_req, 0);
        step();

        // back-to-back loads, each with one wait cycle
        load(32'h10);
        #1;
        chk("bb1_stall", stallM, 1);
        step();
        dmem_ack = 1; dmem_rdata = 32'hA;
        #1;
        chk("bb1_ack_stall", stallM, 0);
        step();
        load(32'h14);
        dmem_rdata = 0;
        #1;
        chk("bb2_req", dmem_req, 1);
        chk("bb1_rdW", readDataW, 32'hA);
        chk("bb1_validW", validW, 1);
        chk("bb1_aluW", ALUResultW, 32'h10);
        step();
        chk("bb2_bubble", validW, 0);
        dmem_ack = 1; dmem_rdata = 32'hB;
        step();
        idle_in();
        #1;
        chk("bb2_rdW", readDataW, 32'hB);
        chk("bb2_aluW", ALUResultW, 32'h14);
        chk("bb2_validW", validW, 1);
        step();

        // misaligned load goes straight to error
        load(32'h102);
        #1;
        chk("mis_req", dmem_req, 0);
        chk("mis_stall", stallM, 1);
        step();
        chk("mis_errW", errW, 1);
        chk("mis_validW", validW, 0);
        load(32'h100);
        dmem_ack = 1;
        #1;
        chk("mis_err_req", dmem_req, 0);
        chk("mis_err_stall", stallM, 1);
        chk("mis_err_pcsrc", pcSrcM, 0);
        step();
        chk("mis_sticky", errW, 1);
        do_reset();
        chk("mis_reset_errW", errW, 0);
        chk("mis_reset_stall", stallM, 0);

        // timeout after TIMEOUT=4 unacknowledged cycles
        load(32'h40);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("to_c%0d_errW", c), errW, 0);
            chk($sformatf("to_c%0d_req", c), dmem_req, 1);
        end
        step();
        chk("to_errW", errW, 1);
        chk("to_req", dmem_req, 0);
        chk("to_stall", stallM, 1);
        chk("to_validW", validW, 0);
        do_reset();
        chk("to_reset_errW", errW, 0);
        chk("to_reset_req", dmem_req, 0);

        // async reset mid-WAIT, then a late ack must be ignored
        load(32'h80);
        step();
        chk("ar_wait_stall", stallM, 1);
        #2 reset = 1;
        #1;
        chk("ar_req", dmem_req, 0);
        chk("ar_stall", stallM, 0);
        chk("ar_errW", errW, 0);
        chk("ar_validW", validW, 0);
        idle_in();
        #2 reset = 0;
        step();
        dmem_ack = 1; dmem_rdata = 32'h5555;
        #1;
        chk("late_ack_req", dmem_req, 0);
        chk("late_ack_stall", stallM, 0);
        step();
        chk("late_ack_validW", validW, 0);
        chk("late_ack_rdW", readDataW, 0);
        chk("late_ack_errW", errW, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
